// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART receive path.
// No logic; parity codes, receiver state enum and baud divisor calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int calc_div(input longint clk_freq, input longint baud);
        return int'((clk_freq + 8 * baud) / (16 * baud));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head whenever non-empty.
// Latency: a write is visible on rd_data the cycle after wr_en (no bypass).
// Backpressure: a write while full without a read is dropped and flagged on overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_ok    = rd_en & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_ok    = wr_en & (~full | rd_ok);
    assign overflow = wr_en & ~wr_ok;
    assign level    = count;
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, majority-voted bits, optional parity, FWFT output FIFO.
// Latency: word pushed one cycle after the last stop sample; o_valid the cycle after.
// Backpressure: i_ready pops the FIFO; a good word arriving when full is dropped (o_overrun).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_uart_rx,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W = $clog2(DIV + 1);

    logic                 rx_meta, rx_sync, rx_prev;
    logic                 rx_fall, start_det;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick, mid, bit_end;
    logic [3:0]           os_cnt;
    logic                 samp7, samp8, vote;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    rx_state_e            state_q, state_d;
    logic                 push_d, perr_d, ferr_d;
    logic                 push_q, perr_q, ferr_q;
    logic                 fifo_empty, fifo_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign start_det = (state_q == ST_IDLE) && rx_fall;

    // Bit timing restarts on each start edge so sampling is centred on that edge.
    assign tick = (div_cnt == DIV_W'(DIV - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst || start_det) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (tick) begin
            if (os_cnt == 4'd7) samp7 <= rx_sync;
            if (os_cnt == 4'd8) samp8 <= rx_sync;
        end
    end

    assign mid     = tick && (os_cnt == 4'd9);
    assign bit_end = tick && (os_cnt == 4'd15);
    assign vote    = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall) state_d = ST_START;
            end
            ST_START: begin
                if (mid && vote)  state_d = ST_IDLE;
                else if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
                    state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end
            ST_PAR: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    if (!vote) begin
                        ferr_d  = 1'b1;
                        perr_d  = par_bad;
                        state_d = ST_WAIT_IDLE;
                    end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        perr_d  = par_bad;
                        push_d  = ~par_bad;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg   <= '0;
            par_bad <= 1'b0;
            bit_cnt <= '0;
            push_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            push_q <= push_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            if (start_det) par_bad <= 1'b0;
            if (state_q != state_d) bit_cnt <= '0;
            else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;
            if (state_q == ST_DATA && mid)
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            // Total ones must be odd for odd parity, even for even parity.
            if (state_q == ST_PAR && mid)
                par_bad <= ((^shreg) ^ vote) != (PARITY == PAR_ODD);
        end
    end

    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_valid      = ~fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .wr_en    (push_q),
        .wr_data  (shreg),
        .rd_en    (i_ready),
        .rd_data  (o_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (o_overrun),
        .level    (o_level)
    );

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, power of 2 in the range 2..256.
REQ-007 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 i_rst  in  1  reset; synchronous, active-high.
REQ-009 i_uart_rx  in  1  asynchronous serial line; idle high.
REQ-010 o_data  out  DATA_BITS  received word at the FIFO head.
REQ-011 o_valid  out  1  high when the FIFO is non-empty.
REQ-012 i_ready  in  1  consumer accept; a pop occurs when o_valid and i_ready are both high.
REQ-013 o_parity_err  out  1  one-cycle pulse on a parity mismatch.
REQ-014 o_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
REQ-015 o_overrun  out  1  one-cycle pulse when a good word is dropped because the FIFO is full.
REQ-016 o_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 i_uart_rx SHALL pass through a 2-FF synchroniser; all logic uses only the synchronised value.
REQ-018 The oversample tick SHALL be 16x BAUD, divisor = round(CLK_FREQ/(16*BAUD)) (defaults: 14); the divisor counter restarts at each start-edge detection.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
REQ-020 IDLE -> START on a synchronised high-to-low transition.
REQ-021 Sampling SHALL be a majority vote of the ticks at offsets 7, 8 and 9 within each bit.
REQ-022 START: a voted-high start bit is a glitch and SHALL return the FSM to IDLE with no flag.
REQ-023 DATA: DATA_BITS bits SHALL be shifted in LSB first; after the last bit, go to PAR if PARITY != 0, else to STOP.
REQ-024 PAR: odd parity requires an odd count of ones across data + parity bit; even parity requires an even count.
REQ-025 STOP: STOP_BITS stop bits are sampled; any voted-low stop bit pulses o_frame_err and moves the FSM to WAIT_IDLE.
REQ-026 WAIT_IDLE -> IDLE only after the synchronised line is high; a line held low SHALL NOT retrigger reception.
REQ-027 A word with a parity error or frame error SHALL be discarded (not pushed); both flags MAY pulse in the same cycle.
REQ-028 A good word SHALL be pushed one cycle after the last stop-bit sample point; o_valid rises the following cycle.
REQ-029 The FIFO SHALL be first-word-fall-through: o_data is valid whenever o_valid is high.
REQ-030 On a push while full with no pop, the new word SHALL be dropped, o_overrun SHALL pulse, and FIFO contents SHALL be unchanged.
REQ-031 On a simultaneous push and pop while full, both operations SHALL complete, o_level SHALL stay at FIFO_DEPTH, and there SHALL be no overrun.
REQ-032 On a simultaneous push and pop while empty, the word SHALL be written and o_valid SHALL rise the next cycle (no bypass).
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-034 While i_rst is high: FSM -> IDLE, FIFO emptied, o_level = 0, o_valid = 0, all error flags = 0, synchroniser flops = 1, and o_data = 0.
REQ-035 Reset mid-frame SHALL abort the frame; no partial word is pushed and no flag pulses.
REQ-036 Reception SHALL resume on the first falling edge after i_rst deasserts.

Structure
REQ-037 Package uart_pkg SHALL hold the parity encodings, the FSM state enum, and a divisor-calculation function.
REQ-038 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised in width and depth.

Verification
REQ-039 Send 0x5A (8N1, 25 MHz, 115200 baud, 8680 ns/bit) -> one push, o_data = 0x5A, no flags.
REQ-040 PARITY=2, send 0x5A with parity bit 0 -> accepted; same frame with parity bit 1 -> o_parity_err pulse, nothing pushed.
REQ-041 Stop bit driven low, then line held low for 30 bit times -> exactly one o_frame_err, no push, no further start until the line returns high.
REQ-042 FIFO_DEPTH=4, i_ready=0, send 0x01..0x05 -> o_level = 4, one o_overrun on 0x05; drain yields 0x01..0x04 in order.
REQ-043 A 3-clock low glitch on idle line -> FSM returns to IDLE, no push, no flags.
REQ-044 i_rst asserted during bit 4 of 0xA5, then 0x3C sent -> only 0x3C is received.
